// File: rtl/key_step_decoder.sv
// PS/2 set-2 scan-code decoder: turns make/break byte sequences into held step levels and a start pulse.
// Optional STEP_LAST_WINS_EN: when both directions are held, only the most recently pressed one is asserted.
module key_step_decoder #(
    parameter int TIMEOUT_CYCLES = 650000,
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       stepleft,
    output logic       stepright,
    output logic       stepjump,
    output logic       game_start,
    output logic       seq_error
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0] CODE_E0    = 8'hE0;
    localparam logic [7:0] CODE_F0    = 8'hF0;
    localparam logic [7:0] CODE_A     = 8'h1C;
    localparam logic [7:0] CODE_D     = 8'h23;
    localparam logic [7:0] CODE_W     = 8'h1D;
    localparam logic [7:0] CODE_SPACE = 8'h29;
    localparam logic [7:0] CODE_ENTER = 8'h5A;
    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_RIGHT = 8'h74;
    localparam logic [7:0] CODE_UP    = 8'h75;

    localparam int H_A     = 0;
    localparam int H_D     = 1;
    localparam int H_W     = 2;
    localparam int H_SPACE = 3;
    localparam int H_LEFT  = 4;
    localparam int H_RIGHT = 5;
    localparam int H_UP    = 6;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [6:0]         held_q, held_d;
    logic               enter_held_q, enter_held_d;
    logic               stepleft_q, stepleft_d;
    logic               stepright_q, stepright_d;
    logic               stepjump_q, stepjump_d;
    logic               game_start_q, game_start_d;
    logic               seq_error_q, seq_error_d;

    logic               make_std, make_ext, brk_std, brk_ext;
    logic               enter_make, enter_brk;
    logic               left_grp, right_grp;
    logic               left_make, right_make;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            held_q       <= '0;
            enter_held_q <= 1'b0;
            stepleft_q   <= 1'b0;
            stepright_q  <= 1'b0;
            stepjump_q   <= 1'b0;
            game_start_q <= 1'b0;
            seq_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            held_q       <= held_d;
            enter_held_q <= enter_held_d;
            stepleft_q   <= stepleft_d;
            stepright_q  <= stepright_d;
            stepjump_q   <= stepjump_d;
            game_start_q <= game_start_d;
            seq_error_q  <= seq_error_d;
        end
    end

    // Next-state: a byte always wins over a timeout landing on the same cycle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        seq_error_d = 1'b0;
        if (rx_valid) begin
            cnt_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (rx_data == CODE_E0)      state_d = S_EXT;
                    else if (rx_data == CODE_F0) state_d = S_BRK;
                end
                S_EXT: begin
                    if (rx_data == CODE_F0) state_d = S_EXT_BRK;
                    else                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (cnt_q == CNT_LAST) begin
                state_d     = S_IDLE;
                cnt_d       = '0;
                seq_error_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Output/flag logic: decode the completing byte against the current state
    always_comb begin
        make_std     = rx_valid && (state_q == S_IDLE);
        make_ext     = rx_valid && (state_q == S_EXT);
        brk_std      = rx_valid && (state_q == S_BRK);
        brk_ext      = rx_valid && (state_q == S_EXT_BRK);
        held_d       = held_q;
        enter_make   = 1'b0;
        enter_brk    = 1'b0;

        if (make_std) begin
            case (rx_data)
                CODE_A:     held_d[H_A]     = 1'b1;
                CODE_D:     held_d[H_D]     = 1'b1;
                CODE_W:     held_d[H_W]     = 1'b1;
                CODE_SPACE: held_d[H_SPACE] = 1'b1;
                CODE_ENTER: enter_make      = 1'b1;
                default: ;
            endcase
        end
        if (make_ext) begin
            case (rx_data)
                CODE_LEFT:  held_d[H_LEFT]  = 1'b1;
                CODE_RIGHT: held_d[H_RIGHT] = 1'b1;
                CODE_UP:    held_d[H_UP]    = 1'b1;
                CODE_ENTER: enter_make      = 1'b1;
                default: ;
            endcase
        end
        if (brk_std) begin
            case (rx_data)
                CODE_A:     held_d[H_A]     = 1'b0;
                CODE_D:     held_d[H_D]     = 1'b0;
                CODE_W:     held_d[H_W]     = 1'b0;
                CODE_SPACE: held_d[H_SPACE] = 1'b0;
                CODE_ENTER: enter_brk       = 1'b1;
                default: ;
            endcase
        end
        if (brk_ext) begin
            case (rx_data)
                CODE_LEFT:  held_d[H_LEFT]  = 1'b0;
                CODE_RIGHT: held_d[H_RIGHT] = 1'b0;
                CODE_UP:    held_d[H_UP]    = 1'b0;
                CODE_ENTER: enter_brk       = 1'b1;
                default: ;
            endcase
        end

        // Only the first make after a break starts the game; typematic repeats are swallowed
        game_start_d = enter_make && !enter_held_q;
        enter_held_d = enter_held_q;
        if (enter_make)     enter_held_d = 1'b1;
        else if (enter_brk) enter_held_d = 1'b0;

        left_grp   = held_d[H_A] | held_d[H_LEFT];
        right_grp  = held_d[H_D] | held_d[H_RIGHT];
        left_make  = (make_std && rx_data == CODE_A) || (make_ext && rx_data == CODE_LEFT);
        right_make = (make_std && rx_data == CODE_D) || (make_ext && rx_data == CODE_RIGHT);
        stepjump_d = held_d[H_W] | held_d[H_SPACE] | held_d[H_UP];
    end

`ifdef STEP_LAST_WINS_EN
    logic last_left_q, last_left_d;

    always_comb begin
        last_left_d = last_left_q;
        if (left_make)       last_left_d = 1'b1;
        else if (right_make) last_left_d = 1'b0;
        stepleft_d  = left_grp  && (!right_grp || last_left_d);
        stepright_d = right_grp && (!left_grp  || !last_left_d);
    end

    // Resets to "right was last"
    always_ff @(posedge clk) begin
        if (rst) last_left_q <= 1'b0;
        else     last_left_q <= last_left_d;
    end
`else
    logic unused_make;

    always_comb begin
        stepleft_d  = left_grp;
        stepright_d = right_grp;
        unused_make = left_make ^ right_make;
    end
`endif

    assign stepleft   = stepleft_q;
    assign stepright  = stepright_q;
    assign stepjump   = stepjump_q;
    assign game_start = game_start_q;
    assign seq_error  = seq_error_q;

endmodule

// File: tb/tb_key_step_decoder.sv
// Directed-vector bench for key_step_decoder with a shortened prefix timeout.
module tb_key_step_decoder;

    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       stepleft, stepright, stepjump, game_start, seq_error;

    int errors = 0;
    int checks = 0;
    int gs_pulses = 0;

    key_step_decoder #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .stepleft   (stepleft),
        .stepright  (stepright),
        .stepjump   (stepjump),
        .game_start (game_start),
        .seq_error  (seq_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (game_start) gs_pulses <= gs_pulses + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one byte for one cycle; returns 1 ns after the sampling edge
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int early;
        int gs0;
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_left",  stepleft,   1'b0);
        check("rst_right", stepright,  1'b0);
        check("rst_jump",  stepjump,   1'b0);
        check("rst_start", game_start, 1'b0);
        check("rst_err",   seq_error,  1'b0);

        // A make/break, with a typematic repeat in between
        send(8'h1C); check("a_make", stepleft, 1'b1);
        send(8'h1C); check("a_rep", stepleft, 1'b1);
        send(8'hF0); check("a_f0_hold", stepleft, 1'b1);
        send(8'h1C); check("a_brk", stepleft, 1'b0);

        // Up arrow alone, then jump held by three sources
        send(8'hE0); check("up_e0", stepjump, 1'b0);
        send(8'h75); check("up_make", stepjump, 1'b1);
        send(8'hE0); send(8'hF0); send(8'h75); check("up_brk", stepjump, 1'b0);
        send(8'h29); send(8'h1D); send(8'hE0); send(8'h75);
        check("jump_all", stepjump, 1'b1);
        send(8'hE0); send(8'hF0); send(8'h75); check("jump_up_rel", stepjump, 1'b1);
        send(8'hF0); send(8'h29); check("jump_sp_rel", stepjump, 1'b1);
        send(8'hF0); send(8'h1D); check("jump_w_rel", stepjump, 1'b0);

        // Enter: repeats suppressed until a break
        gs0 = gs_pulses;
        send(8'h5A); check("ent1", game_start, 1'b1);
        tick();      check("ent1_width", game_start, 1'b0);
        send(8'h5A); check("ent2", game_start, 1'b0);
        send(8'h5A); check("ent3", game_start, 1'b0);
        send(8'hF0); send(8'h5A); check("ent_brk", game_start, 1'b0);
        send(8'h5A); check("ent4", game_start, 1'b1);
        tick();
        check("ent_count", gs_pulses - gs0, 2);

        // Keypad Enter via E0 after a plain-Enter break
        send(8'hF0); send(8'h5A);
        send(8'hE0); send(8'h5A); check("kp_enter", game_start, 1'b1);
        send(8'hE0); send(8'hF0); send(8'h5A);

        // Prefix mismatches and protocol bytes are ignored
        send(8'h74); check("right_noprefix", stepright, 1'b0);
        send(8'hE0); send(8'h1C); check("a_with_e0", stepleft, 1'b0);
        send(8'hFA); send(8'hAA); send(8'h23); check("d_after_ack", stepright, 1'b1);
        send(8'hF0); send(8'h23); check("d_brk", stepright, 1'b0);

        // Prefix timeout
        send(8'hE0);
        early = 0;
        repeat (TO - 1) begin
            tick();
            if (seq_error) early++;
        end
        check("to_early", early, 0);
        tick(); check("to_fire", seq_error, 1'b1);
        tick(); check("to_width", seq_error, 1'b0);
        send(8'h74); check("to_idle", stepright, 1'b0);

        // Byte lands on the timeout cycle: processed, no error
        send(8'hE0);
        repeat (TO - 1) @(posedge clk);
        send(8'h74);
        check("to_race_right", stepright, 1'b1);
        check("to_race_err", seq_error, 1'b0);
        tick(); check("to_race_err2", seq_error, 1'b0);
        send(8'hE0); send(8'hF0); send(8'h74); check("right_brk", stepright, 1'b0);

        // Reset in the middle of a break sequence
        send(8'h23); check("d_hold", stepright, 1'b1);
        send(8'hF0);
        @(negedge clk); rst = 1'b1;
        tick();
        @(negedge clk); rst = 1'b0;
        check("mrst_right", stepright, 1'b0);
        check("mrst_left",  stepleft,  1'b0);
        check("mrst_jump",  stepjump,  1'b0);
        send(8'h23); check("mrst_d", stepright, 1'b1);
        send(8'hF0); send(8'h23); check("mrst_d_brk", stepright, 1'b0);

        // Both directions held
        send(8'h1C); send(8'h23);
`ifdef STEP_LAST_WINS_EN
        check("both_left",  stepleft,  1'b0);
`else
        check("both_left",  stepleft,  1'b1);
`endif
        check("both_right", stepright, 1'b1);
        send(8'hF0); send(8'h23);
        check("rel_right_left",  stepleft,  1'b1);
        check("rel_right_right", stepright, 1'b0);
        send(8'hF0); send(8'h1C); check("rel_all", stepleft, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
